// File: rtl/ram_fifo1rw.sv
// FIFO backed by a single-port registered RAM, with a 3-entry output buffer.
// Optional RAM_FIFO_BYPASS_EN: pushes into an empty FIFO skip the RAM and land in the buffer.
module ram_fifo1rw #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    input  logic                out_ready,
    output logic [LG_DEPTH+1:0] count
);

    localparam int unsigned Depth = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] RamFull = (LG_DEPTH + 1)'(Depth);

    // RAM storage and its registered port (reg_ram1rw behaviour)
    logic [WIDTH-1:0]    r_mem [Depth];
    logic [LG_DEPTH-1:0] r_ram_addr;
    logic [WIDTH-1:0]    r_ram_wdata;
    logic                r_ram_we;
    logic [WIDTH-1:0]    r_ram_rdata;

    logic [LG_DEPTH-1:0] r_wp;
    logic [LG_DEPTH-1:0] r_rp;
    logic [LG_DEPTH:0]   r_ram_cnt;
    logic                r_p1;
    logic                r_p2;

    logic [WIDTH-1:0]    r_ob [3];
    logic [1:0]          r_ob_wr;
    logic [1:0]          r_ob_rd;
    logic [1:0]          r_ob_cnt;

    logic [2:0]          w_occ;
    logic                w_rd_elig;
    logic                w_push;
    logic                w_pop;
    logic                w_bypass;
    logic                w_wr;
    logic                w_ob_in;
    logic [WIDTH-1:0]    w_ob_din;
    logic [LG_DEPTH-1:0] w_ram_addr;
    logic [LG_DEPTH:0]   w_ram_cnt_nxt;
    logic [1:0]          w_ob_cnt_nxt;

    always_comb begin
        w_occ     = 3'(r_ob_cnt) + 3'(r_p1) + 3'(r_p2);
        // Every in-flight read holds a reserved buffer slot
        w_rd_elig = (r_ram_cnt != '0) && (w_occ < 3'd3);
        in_ready  = !w_rd_elig && (r_ram_cnt != RamFull);
        out_valid = (r_ob_cnt != 2'd0);
        out_data  = r_ob[r_ob_rd];
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
`ifdef RAM_FIFO_BYPASS_EN
        w_bypass  = (r_ram_cnt == '0) && !r_p1 && !r_p2 && (r_ob_cnt != 2'd3);
`else
        w_bypass  = 1'b0;
`endif
        w_wr       = w_push && !w_bypass;
        w_ob_in    = r_p2 || (w_push && w_bypass);
        w_ob_din   = r_p2 ? r_ram_rdata : in_data;
        w_ram_addr = w_rd_elig ? r_rp : r_wp;

        w_ram_cnt_nxt = r_ram_cnt;
        if (w_wr) begin
            w_ram_cnt_nxt = r_ram_cnt + (LG_DEPTH + 1)'(1);
        end else if (w_rd_elig) begin
            w_ram_cnt_nxt = r_ram_cnt - (LG_DEPTH + 1)'(1);
        end

        w_ob_cnt_nxt = r_ob_cnt;
        if (w_ob_in && !w_pop) begin
            w_ob_cnt_nxt = r_ob_cnt + 2'd1;
        end else if (!w_ob_in && w_pop) begin
            w_ob_cnt_nxt = r_ob_cnt - 2'd1;
        end

        count = (LG_DEPTH + 2)'(r_ram_cnt) + (LG_DEPTH + 2)'(r_p1) + (LG_DEPTH + 2)'(r_p2)
              + (LG_DEPTH + 2)'(r_ob_cnt);
    end

    // Write commits one edge after registration, so a read issued next cycle sees it
    always_ff @(posedge clk) begin
        r_ram_addr  <= w_ram_addr;
        r_ram_wdata <= in_data;
        if (r_ram_we) begin
            r_mem[r_ram_addr] <= r_ram_wdata;
        end
        r_ram_rdata <= r_mem[r_ram_addr];
        if (w_ob_in) begin
            r_ob[r_ob_wr] <= w_ob_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_we  <= 1'b0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_ram_cnt <= '0;
            r_p1      <= 1'b0;
            r_p2      <= 1'b0;
            r_ob_wr   <= 2'd0;
            r_ob_rd   <= 2'd0;
            r_ob_cnt  <= 2'd0;
        end else begin
            r_ram_we  <= w_wr;
            r_ram_cnt <= w_ram_cnt_nxt;
            r_p1      <= w_rd_elig;
            r_p2      <= r_p1;
            r_ob_cnt  <= w_ob_cnt_nxt;
            if (w_wr) begin
                r_wp <= r_wp + LG_DEPTH'(1);
            end
            if (w_rd_elig) begin
                r_rp <= r_rp + LG_DEPTH'(1);
            end
            if (w_ob_in) begin
                r_ob_wr <= (r_ob_wr == 2'd2) ? 2'd0 : r_ob_wr + 2'd1;
            end
            if (w_pop) begin
                r_ob_rd <= (r_ob_rd == 2'd2) ? 2'd0 : r_ob_rd + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo1rw.sv
// Randomized self-checking bench for ram_fifo1rw against a queue reference model.
module tb_ram_fifo1rw;

    localparam int W    = 32;
    localparam int LG   = 4;
    localparam int D    = 1 << LG;
    localparam int MAXC = D + 3;
`ifdef RAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [LG+1:0] count;

    int            n_total;
    int            n_bad;
    logic [W-1:0]  q[$];

    ram_fifo1rw #(.WIDTH(W), .LG_DEPTH(LG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, observe handshakes mid-cycle, update model, check occupancy.
    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy,
                         output bit acc, output bit ov);
        logic [W-1:0] exp;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready;
        ov  = out_valid;
        if (out_valid && out_ready) begin
            exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
            check_eq("pop_data", out_data, exp);
        end
        if (acc) q.push_back(d);
        @(posedge clk);
        #1;
        check_eq("count", 32'(count), 32'(q.size()));
    endtask

    task automatic drain(input string tag);
        bit acc, ov;
        for (int k = 0; k < 400 && q.size() > 0; k++) cycle(1'b0, '0, 1'b1, acc, ov);
        check_eq(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic fill(input int n, input logic [W-1:0] base, input string tag);
        bit acc, ov;
        int got;
        got = 0;
        for (int k = 0; k < 400 && got < n; k++) begin
            cycle(1'b1, base + W'(got), 1'b0, acc, ov);
            if (acc) got++;
        end
        check_eq(tag, 32'(got), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, ov;
        int lat;
        int sent;
        bit iv, ordy;
        logic [W-1:0] front;

        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);

        // Single-item latency
        cycle(1'b1, 32'hA5, 1'b1, acc, ov);
        check_eq("a5_accept", 32'(acc), 32'd1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            cycle(1'b0, '0, 1'b1, acc, ov);
            if (ov) lat = k;
        end
        check_eq("a5_latency", 32'(lat), 32'(LAT));

        // Fill to capacity with no pops, then drain in order
        fill(MAXC, 32'd0, "fill_accepted");
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h99, 1'b0, acc, ov);
            check_eq("full_no_accept", 32'(acc), 32'd0);
        end
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_count", 32'(count), 32'(MAXC));
        drain("full_drain");
        cycle(1'b0, '0, 1'b1, acc, ov);
        check_eq("drained_out_valid", 32'(ov), 32'd0);

        // Random traffic through many pointer wraps
        sent = 0;
        for (int k = 0; k < 4000 && (sent < 100 || q.size() > 0); k++) begin
            iv   = (sent < 100) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 3) != 0);
            cycle(iv, 32'd1000 + W'(sent), ordy, acc, ov);
            if (acc) sent++;
        end
        check_eq("rand_sent", 32'(sent), 32'd100);
        check_eq("rand_empty", 32'(q.size()), 32'd0);

        // Output stall keeps head stable
        fill(8, 32'h500, "stall_fill");
        for (int k = 0; k < 10 && !out_valid; k++) cycle(1'b0, '0, 1'b0, acc, ov);
        front = q[0];
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, '0, 1'b0, acc, ov);
            check_eq("stall_valid", 32'(ov), 32'd1);
            check_eq("stall_data", out_data, front);
        end
        drain("stall_drain");

        // Reset with data held and a read in flight
        fill(7, 32'h700, "mid_fill");
        cycle(1'b0, '0, 1'b0, acc, ov);
        check_eq("mid_count", 32'(count), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, acc, ov);
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);
        cycle(1'b1, 32'h5A, 1'b1, acc, ov);
        check_eq("post_rst_accept", 32'(acc), 32'd1);
        drain("post_rst_drain");

        // Read-after-write on the same RAM entry
        fill(D - 1, 32'h200, "raw_fill");
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) cycle(1'b1, 32'h33, 1'b1, acc, ov);
        check_eq("raw_accept", 32'(acc), 32'd1);
        drain("raw_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
